led_cube_anim_player: RTL and testbench

Parametrised N×N×N LED cube animation engine. It replaces the fixed 8-cube, free-running multi-frame driver with a single block that both scans the cube (row fetch, latch, layer dwell) and sequences frames. The frame-advance policy is runtime-selectable: loop, once or ping-pong. Frame data comes from an external synchronous ROM/RAM with one-cycle read latency. Outputs drive the cube's layer, latch and data GPIO buses directly.

---
 rtl/led_cube_pkg.sv | 44 ++++
 rtl/led_cube_layer_scan.sv | 167 ++++++++++++++++
 rtl/led_cube_anim_player.sv | 163 ++++++++++++++++
 tb/tb_led_cube_anim_player.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_cube_pkg.sv
// Shared types and helpers for the LED cube animation player.
// Optional build macro: LED_CUBE_DIM_EN (per-layer dimming, see led_cube_layer_scan).
package led_cube_pkg;

    localparam int unsigned MAX_N  = 64;
    localparam int unsigned MAX_NW = 6;

    typedef enum logic [1:0] {
        LOOP     = 2'b00,
        ONCE     = 2'b01,
        PINGPONG = 2'b10
    } play_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        LATCH = 2'b10,
        DWELL = 2'b11
    } scan_state_e;

    // Callers truncate the result to their own bus width.
    function automatic logic [MAX_N-1:0] onehot(input int unsigned idx, input int unsigned n);
        logic [MAX_N-1:0] v;
        v = '0;
        if ((idx < n) && (idx < MAX_N)) begin
            v[idx[MAX_NW-1:0]] = 1'b1;
        end else begin
            v = '0;
        end
        return v;
    endfunction

    // The unused encoding 2'b11 plays as LOOP.
    function automatic play_mode_e decode_mode(input logic [1:0] m);
        play_mode_e r;
        case (m)
            2'b01:   r = ONCE;
            2'b10:   r = PINGPONG;
            default: r = LOOP;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/led_cube_layer_scan.sv
// Row fetch / latch / layer dwell sequencer for one frame of the cube.
// With LED_CUBE_DIM_EN defined, brightness_i shortens the lit part of each dwell.
module led_cube_layer_scan
    import led_cube_pkg::*;
#(
    parameter int unsigned N           = 8,
    parameter int unsigned LAYER_DWELL = 2048,
    parameter int unsigned FW          = 6,
    parameter int unsigned AW          = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic          stop_i,
`ifdef LED_CUBE_DIM_EN
    input  logic [3:0]    brightness_i,
`endif
    input  logic [FW-1:0] frame_i,
    input  logic [N-1:0]  mem_rdata_i,
    output logic [AW-1:0] mem_addr_o,
    output logic [N-1:0]  layers_o,
    output logic [N-1:0]  latches_o,
    output logic [N-1:0]  data_o,
    output logic          busy_o,
    output logic          frame_boundary_o
);

    localparam int unsigned RW       = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW       = $clog2(LAYER_DWELL);
    localparam logic [RW-1:0] LAST_IDX = RW'(N - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LAYER_DWELL - 1);

    scan_state_e   state_q, state_d;
    logic [RW-1:0] row_q, row_d, layer_q, layer_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [N-1:0]  layers_q, layers_d, latches_q, latches_d, data_q, data_d;
    logic          busy_q;
`ifdef LED_CUBE_DIM_EN
    logic [3:0]    bright_q, bright_d;
    logic [CW:0]   on_len_s;

    assign on_len_s = (CW + 1)'((32'(bright_q) + 32'd1) * (LAYER_DWELL / 16));
`endif

    // frame_i is the frame index being committed this cycle, so a new frame's first fetch uses it.
    function automatic logic [AW-1:0] row_addr(input logic [FW-1:0] f, input logic [RW-1:0] l,
                                               input logic [RW-1:0] r);
        return AW'(f) * AW'(N * N) + AW'(l) * AW'(N) + AW'(r);
    endfunction

    assign frame_boundary_o = (state_q == DWELL) && (cnt_q == CNT_LAST) && (layer_q == LAST_IDX);

    // Next-state and next-output logic of the scan sequencer.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        layer_d   = layer_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        layers_d  = '0;
        latches_d = '0;
        data_d    = data_q;
`ifdef LED_CUBE_DIM_EN
        bright_d  = bright_q;
`endif
        if (stop_i) begin
            state_d = IDLE;
            row_d   = '0;
            layer_d = '0;
            cnt_d   = '0;
            addr_d  = '0;
            data_d  = '0;
        end else if (start_i) begin
            state_d = FETCH;
            row_d   = '0;
            layer_d = '0;
            cnt_d   = '0;
            data_d  = '0;
            addr_d  = row_addr(frame_i, '0, '0);
        end else begin
            case (state_q)
                IDLE:  state_d = IDLE;
                FETCH: state_d = LATCH;
                LATCH: begin
                    data_d    = mem_rdata_i;
                    latches_d = N'(onehot(32'(row_q), N));
                    if (row_q == LAST_IDX) begin
                        row_d    = '0;
                        cnt_d    = '0;
                        state_d  = DWELL;
                        layers_d = N'(onehot(32'(layer_q), N));
`ifdef LED_CUBE_DIM_EN
                        bright_d = brightness_i;
`endif
                    end else begin
                        row_d   = row_q + RW'(1);
                        state_d = FETCH;
                        addr_d  = row_addr(frame_i, layer_q, row_q + RW'(1));
                    end
                end
                DWELL: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = FETCH;
                        if (layer_q == LAST_IDX) begin
                            layer_d = '0;
                        end else begin
                            layer_d = layer_q + RW'(1);
                        end
                        addr_d = row_addr(frame_i, layer_d, '0);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
`ifdef LED_CUBE_DIM_EN
                        if ({1'b0, cnt_d} < on_len_s) begin
                            layers_d = N'(onehot(32'(layer_q), N));
                        end else begin
                            layers_d = '0;
                        end
`else
                        layers_d = N'(onehot(32'(layer_q), N));
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Scan state and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            row_q     <= '0;
            layer_q   <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
            layers_q  <= '0;
            latches_q <= '0;
            data_q    <= '0;
            busy_q    <= 1'b0;
`ifdef LED_CUBE_DIM_EN
            bright_q  <= 4'd0;
`endif
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            layer_q   <= layer_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            layers_q  <= layers_d;
            latches_q <= latches_d;
            data_q    <= data_d;
            busy_q    <= (state_d != IDLE);
`ifdef LED_CUBE_DIM_EN
            bright_q  <= bright_d;
`endif
        end
    end

    assign mem_addr_o = addr_q;
    assign layers_o   = layers_q;
    assign latches_o  = latches_q;
    assign data_o     = data_q;
    assign busy_o     = busy_q;

endmodule

// File: rtl/led_cube_anim_player.sv
// N x N x N LED cube animation player: frame timer, play mode and frame index around the layer scanner.
// Optional build macro: LED_CUBE_DIM_EN adds the brightness_i dimming input.
module led_cube_anim_player
    import led_cube_pkg::*;
#(
    parameter  int unsigned N           = 8,
    parameter  int unsigned NUM_FRAMES  = 64,
    parameter  int unsigned LAYER_DWELL = 2048,
    parameter  int unsigned TW          = 21,
    localparam int unsigned AW          = $clog2(NUM_FRAMES * N * N),
    localparam int unsigned FW          = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic          stop_i,
    input  logic          pause_i,
    input  logic [1:0]    mode_i,
    input  logic [TW-1:0] frame_period_i,
`ifdef LED_CUBE_DIM_EN
    input  logic [3:0]    brightness_i,
`endif
    output logic [AW-1:0] mem_addr_o,
    input  logic [N-1:0]  mem_rdata_i,
    output logic [N-1:0]  layers_o,
    output logic [N-1:0]  latches_o,
    output logic [N-1:0]  data_o,
    output logic          busy_o,
    output logic [FW-1:0] frame_idx_o,
    output logic          frame_adv_o,
    output logic          done_o
);

    localparam logic [FW-1:0] LAST_FRAME = FW'(NUM_FRAMES - 1);

    play_mode_e    mode_q, mode_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          dir_up_q, dir_up_d;
    logic          ended_q, ended_d;
    logic          done_q, done_d;
    logic          adv_q;
    logic          busy_s, boundary_s, adv_ok_s;

    led_cube_layer_scan #(
        .N           (N),
        .LAYER_DWELL (LAYER_DWELL),
        .FW          (FW),
        .AW          (AW)
    ) u_scan (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_i          (start_i),
        .stop_i           (stop_i),
`ifdef LED_CUBE_DIM_EN
        .brightness_i     (brightness_i),
`endif
        .frame_i          (frame_d),
        .mem_rdata_i      (mem_rdata_i),
        .mem_addr_o       (mem_addr_o),
        .layers_o         (layers_o),
        .latches_o        (latches_o),
        .data_o           (data_o),
        .busy_o           (busy_s),
        .frame_boundary_o (boundary_s)
    );

    assign adv_ok_s = boundary_s && !pause_i && (timer_q >= frame_period_i);

    // Frame timer, play-mode sequencing and frame index selection.
    always_comb begin
        frame_d  = frame_q;
        dir_up_d = dir_up_q;
        timer_d  = timer_q;
        mode_d   = mode_q;
        ended_d  = ended_q;
        done_d   = 1'b0;
        if (stop_i) begin
            timer_d = '0;
        end else if (start_i) begin
            frame_d  = '0;
            dir_up_d = 1'b1;
            timer_d  = '0;
            mode_d   = decode_mode(mode_i);
            ended_d  = 1'b0;
        end else begin
            if (busy_s && !pause_i && (timer_q < frame_period_i)) begin
                timer_d = timer_q + TW'(1);
            end else begin
                timer_d = timer_q;
            end
            if (adv_ok_s) begin
                timer_d = '0;
                case (mode_q)
                    ONCE: begin
                        if (frame_q == LAST_FRAME) begin
                            done_d  = !ended_q;
                            ended_d = 1'b1;
                        end else begin
                            frame_d = frame_q + FW'(1);
                        end
                    end
                    PINGPONG: begin
                        // A single stored frame has nowhere to bounce to.
                        if (NUM_FRAMES == 1) begin
                            frame_d = frame_q;
                        end else if (dir_up_q) begin
                            if (frame_q == LAST_FRAME) begin
                                dir_up_d = 1'b0;
                                frame_d  = frame_q - FW'(1);
                            end else begin
                                frame_d  = frame_q + FW'(1);
                            end
                        end else begin
                            if (frame_q == '0) begin
                                dir_up_d = 1'b1;
                                frame_d  = frame_q + FW'(1);
                            end else begin
                                frame_d  = frame_q - FW'(1);
                            end
                        end
                    end
                    default: begin
                        if (frame_q == LAST_FRAME) begin
                            frame_d = '0;
                        end else begin
                            frame_d = frame_q + FW'(1);
                        end
                    end
                endcase
            end else begin
                frame_d = frame_q;
            end
        end
    end

    // Frame sequencing registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q   <= LOOP;
            frame_q  <= '0;
            timer_q  <= '0;
            dir_up_q <= 1'b1;
            ended_q  <= 1'b0;
            done_q   <= 1'b0;
            adv_q    <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            frame_q  <= frame_d;
            timer_q  <= timer_d;
            dir_up_q <= dir_up_d;
            ended_q  <= ended_d;
            done_q   <= done_d;
            adv_q    <= (frame_d != frame_q);
        end
    end

    assign busy_o      = busy_s;
    assign frame_idx_o = frame_q;
    assign frame_adv_o = adv_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_led_cube_anim_player.sv
// Scoreboard bench for led_cube_anim_player (N=4, 4 frames, 16-cycle dwell, 96-cycle scan).
module tb_led_cube_anim_player;

    localparam int N  = 4;
    localparam int NF = 4;
    localparam int LD = 16;
    localparam int TW = 21;
    localparam int AW = 6;
    localparam int FW = 2;

    typedef struct {
        int cyc;
        int idx;
    } adv_exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          pause = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [TW-1:0] frame_period = '0;
    logic [AW-1:0] mem_addr;
    logic [N-1:0]  mem_rdata = '0;
    logic [N-1:0]  layers, latches, data;
    logic          busy, frame_adv, done;
    logic [FW-1:0] frame_idx;
`ifdef LED_CUBE_DIM_EN
    logic [3:0]    brightness = 4'd15;
`endif

    int       cyc = 0;
    int       t0 = 0;
    int       n_cmp = 0;
    int       n_mis = 0;
    adv_exp_t adv_q[$];
    int       done_q[$];
    adv_exp_t mon_e;
    int       mon_d;

    led_cube_anim_player #(
        .N           (N),
        .NUM_FRAMES  (NF),
        .LAYER_DWELL (LD),
        .TW          (TW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start),
        .stop_i         (stop),
        .pause_i        (pause),
        .mode_i         (mode),
        .frame_period_i (frame_period),
`ifdef LED_CUBE_DIM_EN
        .brightness_i   (brightness),
`endif
        .mem_addr_o     (mem_addr),
        .mem_rdata_i    (mem_rdata),
        .layers_o       (layers),
        .latches_o      (latches),
        .data_o         (data),
        .busy_o         (busy),
        .frame_idx_o    (frame_idx),
        .frame_adv_o    (frame_adv),
        .done_o         (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous ROM, one cycle latency, content = low address bits.
    always @(posedge clk) mem_rdata <= mem_addr[N-1:0];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Pops expected frame advances and done pulses as the DUT produces them.
    always @(negedge clk) begin
        if (rst_n && frame_adv) begin
            if (adv_q.size() == 0) begin
                check_eq("adv_extra", 32'(frame_adv), 32'd0);
            end else begin
                mon_e = adv_q.pop_front();
                check_eq("adv_idx", 32'(frame_idx), 32'(mon_e.idx));
                check_eq("adv_cyc", 32'(cyc), 32'(mon_e.cyc));
            end
        end
        if (rst_n && done) begin
            if (done_q.size() == 0) begin
                check_eq("done_extra", 32'(done), 32'd0);
            end else begin
                mon_d = done_q.pop_front();
                check_eq("done_cyc", 32'(cyc), 32'(mon_d));
            end
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        pause = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic start_play(input logic [1:0] m, input int fp);
        mode         = m;
        frame_period = TW'(fp);
        start        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        t0    = cyc;
    endtask

    task automatic push_adv(input int c, input int i);
        adv_exp_t e;
        e.cyc = c;
        e.idx = i;
        adv_q.push_back(e);
    endtask

    task automatic count_dwell(output int n);
        n = 0;
        for (int k = 8; k < 24; k++) begin
            wait_until(t0 + k);
            if (layers == 4'b0001) n++;
        end
    endtask

    task automatic check_drained(input string tag);
        check_eq({tag, "_adv_left"}, 32'(adv_q.size()), 32'd0);
        check_eq({tag, "_done_left"}, 32'(done_q.size()), 32'd0);
        adv_q.delete();
        done_q.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: cycle %0d exceeded budget", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n_on;
        int n_lat;
        int n_lay;

        // Reset state
        do_reset();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_layers", 32'(layers), 32'd0);
        check_eq("rst_latches", 32'(latches), 32'd0);
        check_eq("rst_data", 32'(data), 32'd0);
        check_eq("rst_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_idx", 32'(frame_idx), 32'd0);
        check_eq("rst_adv", 32'(frame_adv), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);

        // LOOP, frame_period 0: scan timing plus advance every 96 cycles
        start_play(2'b00, 0);
        for (int k = 1; k <= 4; k++) push_adv(t0 + 96 * k, k % NF);
        check_eq("loop_busy", 32'(busy), 32'd1);
        check_eq("loop_addr0", 32'(mem_addr), 32'd0);
        check_eq("loop_blank", 32'(layers), 32'd0);
        for (int r = 0; r < N; r++) begin
            wait_until(t0 + 2 + 2 * r);
            check_eq("latch_row", 32'(latches), 32'd1 << r);
            check_eq("data_row", 32'(data), 32'(r));
        end
        count_dwell(n_on);
        check_eq("dwell_len", 32'(n_on), 32'd16);
        wait_until(t0 + 24);
        check_eq("l1_addr", 32'(mem_addr), 32'd4);
        check_eq("l1_blank", 32'(layers), 32'd0);
        wait_until(t0 + 96);
        check_eq("f1_addr", 32'(mem_addr), 32'd16);
        wait_until(t0 + 96 * 4 + 20);
        check_drained("loop");

        // PINGPONG, frame_period 0
        do_reset();
        start_play(2'b10, 0);
        push_adv(t0 + 96 * 1, 1);
        push_adv(t0 + 96 * 2, 2);
        push_adv(t0 + 96 * 3, 3);
        push_adv(t0 + 96 * 4, 2);
        push_adv(t0 + 96 * 5, 1);
        push_adv(t0 + 96 * 6, 0);
        push_adv(t0 + 96 * 7, 1);
        wait_until(t0 + 96 * 7 + 20);
        check_drained("pp");

        // ONCE, frame_period 200: advance every third boundary, done once at the end
        do_reset();
        start_play(2'b01, 200);
        push_adv(t0 + 288, 1);
        push_adv(t0 + 576, 2);
        push_adv(t0 + 864, 3);
        done_q.push_back(t0 + 1152);
        wait_until(t0 + 1152 + 300);
        check_eq("once_idx", 32'(frame_idx), 32'd3);
        check_eq("once_busy", 32'(busy), 32'd1);
        check_drained("once");

        // Pause across three boundaries: no advances but the scan keeps running
        do_reset();
        start_play(2'b00, 0);
        push_adv(t0 + 96, 1);
        wait_until(t0 + 100);
        pause = 1'b1;
        n_lat = 0;
        n_lay = 0;
        for (int k = 100; k < 388; k++) begin
            wait_until(t0 + k);
            if (latches != '0) n_lat++;
            if (layers != '0) n_lay++;
        end
        wait_until(t0 + 388);
        pause = 1'b0;
        check_eq("pause_latches", 32'(n_lat), 32'd48);
        check_eq("pause_layers", 32'(n_lay), 32'd192);
        push_adv(t0 + 480, 2);
        wait_until(t0 + 500);
        check_drained("pause");

        // Stop mid-dwell, then start and stop together
        do_reset();
        start_play(2'b00, 0);
        wait_until(t0 + 12);
        check_eq("pre_stop_layers", 32'(layers), 32'd1);
        stop = 1'b1;
        @(posedge clk);
        @(negedge clk);
        stop = 1'b0;
        check_eq("stop_layers", 32'(layers), 32'd0);
        check_eq("stop_latches", 32'(latches), 32'd0);
        check_eq("stop_data", 32'(data), 32'd0);
        check_eq("stop_busy", 32'(busy), 32'd0);
        start = 1'b1;
        stop  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        check_eq("ss_busy", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        check_eq("ss_busy_late", 32'(busy), 32'd0);
        check_eq("ss_addr", 32'(mem_addr), 32'd0);
        check_drained("stop");

`ifdef LED_CUBE_DIM_EN
        // Dimming: lit cycles per dwell follow brightness
        do_reset();
        brightness = 4'd3;
        start_play(2'b00, 0);
        count_dwell(n_on);
        check_eq("dim3_len", 32'(n_on), 32'd4);
        do_reset();
        brightness = 4'd15;
        start_play(2'b00, 0);
        count_dwell(n_on);
        check_eq("dim15_len", 32'(n_on), 32'd16);
        do_reset();
        check_drained("dim");
`endif

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
